// File: rtl/program_loader_pkg.sv
// Shared processor definitions for the program loader: FSM state codes and
// active-low level constants used on the Memory and SequenceControl strobes.
package program_loader_pkg;

   // Loader FSM state encoding (kept as plain constants for legacy tooling)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // Levels for active-low strobes
   localparam logic ASSERTED_N   = 1'b0;
   localparam logic DEASSERTED_N = 1'b1;

endpackage

// File: rtl/program_loader.sv
// Program loader: streams a program image from a valid/ready word source into
// the instruction Memory write port while holding the CPU (SequenceControl)
// in reset, then releases the CPU a fixed number of cycles after the final
// write strobe so the image is complete before the first fetch.
// The integration mux in front of the Memory selects this block while busy_o=1.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] LOAD_BASE   = '0,
   parameter int                    HOLD_CYCLES = 2
)(
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   length_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_wr_no,
   output logic                  cpu_reset_no,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);

   localparam int LEN_W  = ADDR_WIDTH + 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   // Largest legal length: the whole memory (2**ADDR_WIDTH words)
   localparam logic [LEN_W-1:0]  MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   logic [1:0]        state;
   logic [LEN_W-1:0]  count;      // words accepted so far in this load
   logic [LEN_W-1:0]  length_q;   // words requested for this load
   logic [HOLD_W-1:0] hold_q;     // cycles left before the CPU is released
   logic [LEN_W-1:0]  count_next;
   logic              accept;

   // Only LOAD takes words; everything else is registered below
   assign ready_o    = (state == ST_LOAD);
   assign accept     = valid_i & ready_o;
   assign count_next = count + LEN_ONE;

   // Loader FSM, word counter, hold counter and registered Memory/CPU strobes
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         // NOTE: sequential state is assigned with <= so every register samples
         // the pre-edge values of the others, independent of statement order.
         state        <= ST_IDLE;
         count        <= '0;
         length_q     <= '0;
         hold_q       <= '0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         mem_wr_no    <= DEASSERTED_N;
         cpu_reset_no <= DEASSERTED_N;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         // Strobes and pulses last one cycle unless re-asserted below
         mem_wr_no <= DEASSERTED_N;
         done_o    <= 1'b0;
         error_o   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  if (length_i > MAX_LEN) begin
                     error_o <= 1'b1;
                  end else begin
                     cpu_reset_no <= ASSERTED_N;
                     busy_o       <= 1'b1;
                     count        <= '0;
                     length_q     <= length_i;
                     if (length_i == '0) begin
                        // Nothing to write: go straight to the hold period
                        state  <= ST_RELEASE;
                        hold_q <= HOLD_INIT;
                     end else begin
                        state <= ST_LOAD;
                     end
                  end
               end
            end

            ST_LOAD: begin
               if (accept) begin
                  // Address wraps naturally at the top of the memory
                  mem_addr_o <= LOAD_BASE + count[ADDR_WIDTH-1:0];
                  mem_data_o <= data_i;
                  mem_wr_no  <= ASSERTED_N;
                  count      <= count_next;
                  if (count_next == length_q) begin
                     // The last strobe is issued during the first RELEASE cycle
                     state  <= ST_RELEASE;
                     hold_q <= HOLD_INIT;
                  end
               end
            end

            ST_RELEASE: begin
               if (hold_q == '0) begin
                  cpu_reset_no <= DEASSERTED_N;
                  done_o       <= 1'b1;
                  busy_o       <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  hold_q <= hold_q - HOLD_ONE;
               end
            end

            default: begin
               // Unused encoding: recover to IDLE with the CPU running
               state        <= ST_IDLE;
               busy_o       <= 1'b0;
               cpu_reset_no <= DEASSERTED_N;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (LOAD_BASE 0x00 and
// 0xFE) share all stimulus; each has its own BRAM model and a behavioural
// reference that predicts the outputs and memory contents every cycle.
module tb_program_loader;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam int HOLD  = 2;
   localparam logic [AW-1:0] BASE_A = 8'h00;
   localparam logic [AW-1:0] BASE_B = 8'hFE;

   logic          Clock_TB = 1'b0;
   logic          reset_n  = 1'b1;
   logic          start    = 1'b0;
   logic [AW:0]   length   = '0;
   logic [DW-1:0] data     = '0;
   logic          valid    = 1'b0;

   logic          ready_a, wr_n_a, cpu_a, busy_a, done_a, err_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] wdata_a;
   logic          ready_b, wr_n_b, cpu_b, busy_b, done_b, err_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] wdata_b;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;

   always #5 Clock_TB = ~Clock_TB;

   program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_BASE(BASE_A), .HOLD_CYCLES(HOLD)) dut_a (
      .clk_i(Clock_TB), .reset_ni(reset_n), .start_i(start), .length_i(length),
      .data_i(data), .valid_i(valid), .ready_o(ready_a), .mem_addr_o(addr_a),
      .mem_data_o(wdata_a), .mem_wr_no(wr_n_a), .cpu_reset_no(cpu_a),
      .busy_o(busy_a), .done_o(done_a), .error_o(err_a));

   program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_BASE(BASE_B), .HOLD_CYCLES(HOLD)) dut_b (
      .clk_i(Clock_TB), .reset_ni(reset_n), .start_i(start), .length_i(length),
      .data_i(data), .valid_i(valid), .ready_o(ready_b), .mem_addr_o(addr_b),
      .mem_data_o(wdata_b), .mem_wr_no(wr_n_b), .cpu_reset_no(cpu_b),
      .busy_o(busy_b), .done_o(done_b), .error_o(err_b));

   // Instruction memories behind each loader
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];

   // NOTE: the BRAM has no reset; its contents survive a loader reset.
   always @(posedge Clock_TB) begin
      if (wr_n_a == 1'b0) mem_a[addr_a] <= wdata_a;
      if (wr_n_b == 1'b0) mem_b[addr_b] <= wdata_b;
   end

   // ---------------- behavioural reference ----------------
   int            m_left    [2];   // words still to be accepted
   int            m_hold    [2];   // hold cycles left, -1 when not holding
   int            m_written [2];   // words accepted in this load
   bit            m_pend    [2];   // a write commits at the next edge
   logic [AW-1:0] m_paddr   [2];
   logic [DW-1:0] m_pdata   [2];
   logic          e_ready [2], e_wr_n [2], e_cpu [2], e_busy [2], e_done [2], e_err [2];
   logic [AW-1:0] e_addr  [2];
   logic [DW-1:0] e_data  [2];
   logic [DW-1:0] exp_mem [2][DEPTH];

   function automatic int base_of(input int k);
      return (k == 0) ? int'(BASE_A) : int'(BASE_B);
   endfunction

   task automatic model_reset(input int k);
      m_left[k] = 0;  m_hold[k] = -1;  m_written[k] = 0;  m_pend[k] = 1'b0;
      e_ready[k] = 1'b0; e_wr_n[k] = 1'b1; e_cpu[k] = 1'b1; e_busy[k] = 1'b0;
      e_done[k] = 1'b0;  e_err[k] = 1'b0;  e_addr[k] = '0;  e_data[k] = '0;
   endtask

   task automatic model_step(input int k, input logic st, input logic [AW:0] len,
                             input logic vld, input logic [DW-1:0] dat);
      if (m_pend[k]) begin
         exp_mem[k][m_paddr[k]] = m_pdata[k];
         m_pend[k] = 1'b0;
      end
      e_done[k] = 1'b0;
      e_err[k]  = 1'b0;
      e_wr_n[k] = 1'b1;
      if (m_left[k] > 0) begin
         if (vld) begin
            m_paddr[k] = AW'((base_of(k) + m_written[k]) % DEPTH);
            m_pdata[k] = dat;
            m_pend[k]  = 1'b1;
            e_addr[k]  = m_paddr[k];
            e_data[k]  = dat;
            e_wr_n[k]  = 1'b0;
            m_written[k]++;
            m_left[k]--;
            if (m_left[k] == 0) m_hold[k] = HOLD;
         end
      end else if (m_hold[k] >= 0) begin
         if (m_hold[k] == 0) begin
            m_hold[k] = -1;
            e_cpu[k]  = 1'b1;
            e_done[k] = 1'b1;
         end else begin
            m_hold[k]--;
         end
      end else if (st) begin
         if (int'(len) > DEPTH) begin
            e_err[k] = 1'b1;
         end else begin
            e_cpu[k]     = 1'b0;
            m_written[k] = 0;
            if (len == '0) m_hold[k] = HOLD;
            else           m_left[k] = int'(len);
         end
      end
      e_busy[k]  = (m_left[k] > 0) || (m_hold[k] >= 0);
      e_ready[k] = (m_left[k] > 0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input int k, input string tag, input logic rdy, input logic wr_n,
                              input logic cpu, input logic busy, input logic done, input logic err,
                              input logic [AW-1:0] addr, input logic [DW-1:0] dat);
      check({"ctrl_", tag, "(rdy,wr_n,cpu,busy,done,err)"},
            {26'd0, rdy, wr_n, cpu, busy, done, err},
            {26'd0, e_ready[k], e_wr_n[k], e_cpu[k], e_busy[k], e_done[k], e_err[k]});
      if (e_wr_n[k] == 1'b0)
         check({"wbeat_", tag, "(addr,data)"}, {8'd0, addr, dat}, {8'd0, e_addr[k], e_data[k]});
   endtask

   // ---------------- observation logs for literal checks ----------------
   logic [AW-1:0] sa_addr [$];
   logic [DW-1:0] sa_data [$];
   int            sa_cyc  [$];
   logic [AW-1:0] sb_addr [$];
   int cpu_low_a, last_cpu_low_a, done_cnt_a, err_cnt_a;
   bit busy_seen_a;

   task automatic clear_logs();
      sa_addr.delete(); sa_data.delete(); sa_cyc.delete(); sb_addr.delete();
      cpu_low_a = 0; last_cpu_low_a = 0; done_cnt_a = 0; err_cnt_a = 0; busy_seen_a = 1'b0;
   endtask

   // The model resets with the DUT, between edges
   always @(negedge reset_n) begin
      model_reset(0);
      model_reset(1);
   end

   // Single compare process: advance the model at each edge, compare just after
   always @(posedge Clock_TB) begin
      logic          st_s, vld_s;
      logic [AW:0]   len_s;
      logic [DW-1:0] dat_s;
      st_s = start; vld_s = valid; len_s = length; dat_s = data;
      for (int k = 0; k < 2; k++) begin
         if (!reset_n) model_reset(k);
         else          model_step(k, st_s, len_s, vld_s, dat_s);
      end
      #1;
      compare_dut(0, "a", ready_a, wr_n_a, cpu_a, busy_a, done_a, err_a, addr_a, wdata_a);
      compare_dut(1, "b", ready_b, wr_n_b, cpu_b, busy_b, done_b, err_b, addr_b, wdata_b);
      if (wr_n_a === 1'b0) begin
         sa_addr.push_back(addr_a); sa_data.push_back(wdata_a); sa_cyc.push_back(cycle);
      end
      if (wr_n_b === 1'b0) sb_addr.push_back(addr_b);
      if (cpu_a === 1'b0) begin cpu_low_a++; last_cpu_low_a = cycle; end
      if (done_a === 1'b1) done_cnt_a++;
      if (err_a === 1'b1)  err_cnt_a++;
      if (busy_a === 1'b1) busy_seen_a = 1'b1;
      cycle++;
   end

   // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
   task automatic wait_done(input int budget);
      int n = 0;
      while ((busy_a || busy_b) && n < budget) begin
         @(negedge Clock_TB);
         n++;
      end
      check("load_finished_within_budget", {30'd0, busy_a, busy_b}, 32'd0);
   endtask

   task automatic check_mem(input int k);
      int bad = -1;
      int idx;
      for (int i = 0; i < DEPTH; i++)
         if (bad < 0 && ((k == 0) ? mem_a[i] : mem_b[i]) !== exp_mem[k][i]) bad = i;
      idx = (bad < 0) ? 0 : bad;
      check($sformatf("mem_%s[%0d]", (k == 0) ? "a" : "b", idx),
            (k == 0) ? mem_a[idx] : mem_b[idx], exp_mem[k][idx]);
   endtask

   task automatic random_load(input int len, input int pct, input int abort_at);
      int n = 0;
      start = 1'b1; length = (AW+1)'(len); valid = 1'b0;
      @(negedge Clock_TB);
      start = 1'b0;
      while ((busy_a || busy_b) && n < 2000) begin
         valid  = ($urandom_range(0, 99) < pct);
         data   = DW'($urandom);
         start  = ($urandom_range(0, 7) == 0);
         length = (AW+1)'($urandom_range(0, 300));
         if (abort_at > 0 && n == abort_at) begin
            #2 reset_n = 1'b0;
            @(negedge Clock_TB);
            reset_n = 1'b1;
         end else begin
            @(negedge Clock_TB);
         end
         n++;
      end
      start = 1'b0; valid = 1'b0;
      check("random_load_finished", {30'd0, busy_a, busy_b}, 32'd0);
   endtask

   bit vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] <= DW'(i * 37 + 256);
         mem_b[i] <= DW'(i * 37 + 256);
         exp_mem[0][i] = DW'(i * 37 + 256);
         exp_mem[1][i] = DW'(i * 37 + 256);
      end
      model_reset(0);
      model_reset(1);
      clear_logs();
      #1 reset_n = 1'b0;
      repeat (3) @(negedge Clock_TB);
      reset_n = 1'b1;
      @(negedge Clock_TB);

      // 1. Async reset mid-load, between clock edges
      start = 1'b1; length = 9'd3;
      @(negedge Clock_TB); start = 1'b0; valid = 1'b1; data = 16'hC001;
      @(negedge Clock_TB); data = 16'hC002;
      @(negedge Clock_TB); valid = 1'b0;
      check("pre_reset_strobe_low", wr_n_a, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("async_ready",  ready_a, 1'b0);
      check("async_addr",   addr_a,  '0);
      check("async_data",   wdata_a, '0);
      check("async_wr_n",   wr_n_a,  1'b1);
      check("async_cpu",    cpu_a,   1'b1);
      check("async_busy",   busy_a,  1'b0);
      check("async_done",   done_a,  1'b0);
      check("async_err",    err_a,   1'b0);
      @(negedge Clock_TB); reset_n = 1'b1;
      @(negedge Clock_TB);
      check_mem(0); check_mem(1);

      // 2. Back-to-back load of three words
      clear_logs();
      start = 1'b1; length = 9'd3;
      @(negedge Clock_TB); start = 1'b0; valid = 1'b1; data = 16'h1111;
      @(negedge Clock_TB); data = 16'h2222;
      @(negedge Clock_TB); data = 16'h3333;
      @(negedge Clock_TB); valid = 1'b0;
      wait_done(20);
      check("t2_strobes", sa_addr.size(), 3);
      if (sa_addr.size() == 3) begin
         check("t2_addr0", sa_addr[0], 8'h00);
         check("t2_addr1", sa_addr[1], 8'h01);
         check("t2_addr2", sa_addr[2], 8'h02);
         check("t2_consecutive", sa_cyc[2] - sa_cyc[0], 2);
         check("t2_cpu_after_last_strobe", last_cpu_low_a - sa_cyc[2], HOLD);
      end
      check("t2_cpu_low_cycles", cpu_low_a, 3 + HOLD + 1);
      check("t2_done_pulses", done_cnt_a, 1);
      check("t2_mem0", mem_a[0], 16'h1111);
      check("t2_mem1", mem_a[1], 16'h2222);
      check("t2_mem2", mem_a[2], 16'h3333);
      check("t2_model_mem1", exp_mem[0][1], 16'h2222);
      check_mem(0); check_mem(1);

      // 3. Same load with gaps in valid
      clear_logs();
      start = 1'b1; length = 9'd3;
      @(negedge Clock_TB); start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         valid = vpat[i];
         data  = 16'h5A01 + DW'(i);
         @(negedge Clock_TB);
      end
      valid = 1'b0;
      wait_done(20);
      check("t3_strobes", sa_addr.size(), 3);
      if (sa_addr.size() == 3) begin
         check("t3_addr0", sa_addr[0], 8'h00);
         check("t3_addr2", sa_addr[2], 8'h02);
         check("t3_data0", sa_data[0], 16'h5A01);
         check("t3_data1", sa_data[1], 16'h5A04);
         check("t3_data2", sa_data[2], 16'h5A06);
      end
      check("t3_done_pulses", done_cnt_a, 1);
      check_mem(0); check_mem(1);

      // 4. Wrap-around from LOAD_BASE=0xFE (instance b)
      clear_logs();
      start = 1'b1; length = 9'd4;
      @(negedge Clock_TB); start = 1'b0; valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data = 16'h4400 + DW'(i);
         @(negedge Clock_TB);
      end
      valid = 1'b0;
      wait_done(20);
      check("t4_strobes_b", sb_addr.size(), 4);
      if (sb_addr.size() == 4) begin
         check("t4_addr_b0", sb_addr[0], 8'hFE);
         check("t4_addr_b1", sb_addr[1], 8'hFF);
         check("t4_addr_b2", sb_addr[2], 8'h00);
         check("t4_addr_b3", sb_addr[3], 8'h01);
      end
      check("t4_mem_b_fe", mem_b[8'hFE], 16'h4400);
      check("t4_mem_b_01", mem_b[8'h01], 16'h4403);
      check_mem(0); check_mem(1);

      // 5a. Zero-length load: no strobe, CPU held HOLD+1 cycles
      clear_logs();
      start = 1'b1; length = 9'd0;
      @(negedge Clock_TB); start = 1'b0;
      wait_done(20);
      check("t5_no_strobe", sa_addr.size(), 0);
      check("t5_cpu_low_cycles", cpu_low_a, HOLD + 1);
      check("t5_done_pulses", done_cnt_a, 1);

      // 5b. Over-long request is rejected
      clear_logs();
      start = 1'b1; length = 9'd257;
      @(negedge Clock_TB); start = 1'b0;
      repeat (3) @(negedge Clock_TB);
      check("t5_err_pulses", err_cnt_a, 1);
      check("t5_err_busy", busy_seen_a, 1'b0);
      check("t5_err_cpu_low", cpu_low_a, 0);
      check("t5_err_done", done_cnt_a, 0);

      // 6. Reset after two of four words; start during LOAD ignored
      clear_logs();
      start = 1'b1; length = 9'd4;
      @(negedge Clock_TB); start = 1'b0; valid = 1'b1; data = 16'h6601;
      @(negedge Clock_TB); data = 16'h6602;
      @(negedge Clock_TB); valid = 1'b0; start = 1'b1; length = 9'd5;
      @(negedge Clock_TB); start = 1'b0;
      @(posedge Clock_TB);
      #3 reset_n = 1'b0;
      #1;
      check("t6_ready_after_reset", ready_a, 1'b0);
      check("t6_cpu_released", cpu_a, 1'b1);
      check("t6_busy_after_reset", busy_a, 1'b0);
      @(negedge Clock_TB); reset_n = 1'b1;
      @(negedge Clock_TB);
      check("t6_mem0", mem_a[0], 16'h6601);
      check("t6_mem1", mem_a[1], 16'h6602);
      check("t6_mem2_untouched", mem_a[2], 16'h4402);
      check_mem(0); check_mem(1);
      clear_logs();
      start = 1'b1; length = 9'd2;
      @(negedge Clock_TB); start = 1'b0; valid = 1'b1; data = 16'h7701;
      @(negedge Clock_TB); data = 16'h7702;
      @(negedge Clock_TB); valid = 1'b0;
      wait_done(20);
      check("t6_reload_done", done_cnt_a, 1);
      check("t6_reload_mem1", mem_a[1], 16'h7702);
      check_mem(0); check_mem(1);

      // Randomized loads, including a full-memory load and mid-load resets
      for (int t = 0; t < 24; t++) begin
         int r;
         int len;
         int abort_at;
         r = $urandom_range(0, 9);
         if (r == 0)      len = 0;
         else if (r == 1) len = $urandom_range(257, 511);
         else             len = $urandom_range(1, 16);
         if (t == 10) len = 256;
         abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
         random_load(len, $urandom_range(30, 100), abort_at);
         @(negedge Clock_TB);
         check_mem(0); check_mem(1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
